// File: rtl/alu_share_arb.sv
// Round-robin share of one execute-stage ALU between port 0 (integer/address) and port 1 (branch compare).
// Optional ALU_ARB_STATS_EN adds saturating grant/conflict counters.
module alu_share_arb #(
  parameter int DW = 32,
  parameter int OPW = 4,
  parameter int TAGW = 4,
  parameter logic [OPW-1:0] ADD_OP = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [OPW-1:0]  req0_op,
  input  logic [DW-1:0]   req0_a,
  input  logic [DW-1:0]   req0_b,
  input  logic [TAGW-1:0] req0_tag,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [OPW-1:0]  req1_op,
  input  logic [DW-1:0]   req1_a,
  input  logic [DW-1:0]   req1_b,
  input  logic [TAGW-1:0] req1_tag,
  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic [DW-1:0]   rsp0_c,
  output logic            rsp0_f,
  output logic [TAGW-1:0] rsp0_tag,
  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [DW-1:0]   rsp1_c,
  output logic            rsp1_f,
  output logic [TAGW-1:0] rsp1_tag,
  output logic [DW-1:0]   alu_a,
  output logic [DW-1:0]   alu_b,
  output logic [OPW-1:0]  alu_op,
  input  logic [DW-1:0]   alu_c,
  input  logic            alu_f
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [31:0]     stat_gnt0,
  output logic [31:0]     stat_gnt1,
  output logic [31:0]     stat_conflict
`endif
);

  logic elig0, elig1, gnt0, gnt1, contended, rr_ptr;

  // A response register being drained this cycle counts as free.
  assign elig0      = req0_valid & (~rsp0_valid | rsp0_ready);
  assign elig1      = req1_valid & (~rsp1_valid | rsp1_ready);
  assign contended  = elig0 & elig1;
  assign gnt0       = elig0 & (~elig1 | ~rr_ptr);
  assign gnt1       = elig1 & (~elig0 | rr_ptr);
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  always_comb begin
    alu_a  = req0_a;
    alu_b  = req0_b;
    alu_op = gnt0 ? req0_op : ADD_OP;
    if (gnt1) begin
      alu_a  = req1_a;
      alu_b  = req1_b;
      alu_op = req1_op;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= 1'b0;
    end else if (contended) begin
      rr_ptr <= ~rr_ptr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp0_valid <= 1'b0;
      rsp0_c     <= '0;
      rsp0_f     <= 1'b0;
      rsp0_tag   <= '0;
    end else if (gnt0) begin
      rsp0_valid <= 1'b1;
      rsp0_c     <= alu_c;
      rsp0_f     <= alu_f;
      rsp0_tag   <= req0_tag;
    end else if (rsp0_ready) begin
      rsp0_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp1_valid <= 1'b0;
      rsp1_c     <= '0;
      rsp1_f     <= 1'b0;
      rsp1_tag   <= '0;
    end else if (gnt1) begin
      rsp1_valid <= 1'b1;
      rsp1_c     <= alu_c;
      rsp1_f     <= alu_f;
      rsp1_tag   <= req1_tag;
    end else if (rsp1_ready) begin
      rsp1_valid <= 1'b0;
    end
  end

`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_gnt0     <= '0;
      stat_gnt1     <= '0;
      stat_conflict <= '0;
    end else begin
      if (gnt0 && stat_gnt0 != 32'hFFFF_FFFF) stat_gnt0 <= stat_gnt0 + 32'd1;
      if (gnt1 && stat_gnt1 != 32'hFFFF_FFFF) stat_gnt1 <= stat_gnt1 + 32'd1;
      if (contended && stat_conflict != 32'hFFFF_FFFF) stat_conflict <= stat_conflict + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: directed scenarios plus randomized traffic against a transaction-level model.
module tb_alu_share_arb;

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4, OP_SLT = 4'd5, OP_SLL = 4'd6, OP_SRL = 4'd7;
  localparam logic [3:0] OP_BEQ = 4'd8, OP_BNE = 4'd9, OP_BLT = 4'd10, OP_BGE = 4'd11;

  logic clk = 1'b0, rst_n;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0] req0_op, req1_op, req0_tag, req1_tag, rsp0_tag, rsp1_tag, alu_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b, rsp0_c, rsp1_c, alu_a, alu_b, alu_c;
  logic rsp0_valid, rsp0_ready, rsp0_f, rsp1_valid, rsp1_ready, rsp1_f, alu_f;
`ifdef ALU_ARB_STATS_EN
  logic [31:0] stat_gnt0, stat_gnt1, stat_conflict;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_share_arb dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_tag(req1_tag),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_c(rsp0_c),
    .rsp0_f(rsp0_f), .rsp0_tag(rsp0_tag),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_c(rsp1_c),
    .rsp1_f(rsp1_f), .rsp1_tag(rsp1_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c), .alu_f(alu_f)
`ifdef ALU_ARB_STATS_EN
    , .stat_gnt0(stat_gnt0), .stat_gnt1(stat_gnt1), .stat_conflict(stat_conflict)
`endif
  );

  // ALU behaviour: returns {f, c}; branches produce only f, the rest only c.
  function automatic logic [32:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_ADD: return {1'b0, a + b};
      OP_SUB: return {1'b0, a - b};
      OP_AND: return {1'b0, a & b};
      OP_OR:  return {1'b0, a | b};
      OP_XOR: return {1'b0, a ^ b};
      OP_SLT: return {1'b0, 31'd0, ($signed(a) < $signed(b))};
      OP_SLL: return {1'b0, a << b[4:0]};
      OP_SRL: return {1'b0, a >> b[4:0]};
      OP_BEQ: return {(a == b), 32'd0};
      OP_BNE: return {(a != b), 32'd0};
      OP_BLT: return {($signed(a) < $signed(b)), 32'd0};
      OP_BGE: return {($signed(a) >= $signed(b)), 32'd0};
      default: return 33'd0;
    endcase
  endfunction

  always_comb {alu_f, alu_c} = alu_ref(alu_op, alu_a, alu_b);

  task automatic idle();
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
  endtask

  task automatic set_req(input int p, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] tag);
    if (p == 0) begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; req0_tag = tag;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; req1_tag = tag;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    req0_op = '0; req0_a = '0; req0_b = '0; req0_tag = '0;
    req1_op = '0; req1_a = '0; req1_b = '0; req1_tag = '0;
    #12;
    checks++;
    if ({rsp0_valid, rsp0_c, rsp0_f, rsp0_tag} !== 38'd0) begin
      errors++; $display("FAIL reset_rsp0: got v=%0b c=%0h f=%0b t=%0h, want all 0", rsp0_valid, rsp0_c, rsp0_f, rsp0_tag);
    end
    checks++;
    if ({rsp1_valid, rsp1_c, rsp1_f, rsp1_tag} !== 38'd0) begin
      errors++; $display("FAIL reset_rsp1: got v=%0b c=%0h f=%0b t=%0h, want all 0", rsp1_valid, rsp1_c, rsp1_f, rsp1_tag);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    @(negedge clk);
    set_req(0, OP_ADD, 32'd5, 32'd3, 4'd1);
    #1;
    checks++;
    if (req0_ready !== 1'b1 || alu_a !== 32'd5 || alu_b !== 32'd3) begin
      errors++; $display("FAIL single_grant: ready=%0b a=%0d b=%0d, want 1 5 3", req0_ready, alu_a, alu_b);
    end
    @(posedge clk); #1;
    checks++;
    if (rsp0_valid !== 1'b1 || rsp0_c !== 32'd8 || rsp0_tag !== 4'd1) begin
      errors++; $display("FAIL single_rsp: v=%0b c=%0d t=%0d, want 1 8 1", rsp0_valid, rsp0_c, rsp0_tag);
    end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (alu_op !== OP_ADD) begin
      errors++; $display("FAIL idle_aluop: got %0d want %0d", alu_op, OP_ADD);
    end
    @(posedge clk); #1;
    checks++;
    if (rsp0_valid !== 1'b0) begin
      errors++; $display("FAIL single_drain: rsp0_valid=%0b want 0", rsp0_valid);
    end
  endtask

  task automatic test_alternate();
    @(negedge clk);
    set_req(0, OP_SUB, 32'd10, 32'd4, 4'd2);
    set_req(1, OP_BLT, 32'hFFFF_FFFF, 32'd2, 4'd3);
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin
        errors++; $display("FAIL alt_grant%0d: r0=%0b r1=%0b, want port %0d", i, req0_ready, req1_ready, i % 2);
      end
      @(posedge clk); #1;
      checks++;
      if (i % 2 == 0 && (rsp0_valid !== 1'b1 || rsp0_c !== 32'd6 || rsp0_tag !== 4'd2)) begin
        errors++; $display("FAIL alt_rsp0_%0d: v=%0b c=%0d t=%0d, want 1 6 2", i, rsp0_valid, rsp0_c, rsp0_tag);
      end else if (i % 2 == 1 && (rsp1_valid !== 1'b1 || rsp1_f !== 1'b1 || rsp1_tag !== 4'd3)) begin
        errors++; $display("FAIL alt_rsp1_%0d: v=%0b f=%0b t=%0d, want 1 1 3", i, rsp1_valid, rsp1_f, rsp1_tag);
      end
      @(negedge clk);
    end
    idle();
  endtask

  task automatic test_backpressure();
    // One contended cycle to port 0 leaves port 1 favoured for the release below.
    @(negedge clk);
    set_req(0, OP_ADD, 32'd1, 32'd1, 4'd9);
    set_req(1, OP_ADD, 32'd0, 32'd0, 4'd0);
    @(negedge clk);
    req0_valid = 1'b0;
    set_req(1, OP_ADD, 32'd1, 32'd2, 4'd5);
    rsp1_ready = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (rsp1_valid !== 1'b1 || rsp1_c !== 32'd3 || rsp1_tag !== 4'd5) begin
      errors++; $display("FAIL bp_fill: v=%0b c=%0d t=%0d, want 1 3 5", rsp1_valid, rsp1_c, rsp1_tag);
    end
    @(negedge clk);
    set_req(0, OP_XOR, 32'hF0, 32'h0F, 4'd4);
    set_req(1, OP_ADD, 32'd20, 32'd22, 4'd6);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
        errors++; $display("FAIL bp_grant%0d: r0=%0b r1=%0b, want 1 0", i, req0_ready, req1_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (rsp1_valid !== 1'b1 || rsp1_c !== 32'd3 || rsp1_tag !== 4'd5 || rsp0_c !== 32'hFF) begin
        errors++; $display("FAIL bp_hold%0d: rsp1 c=%0d t=%0d rsp0 c=%0h, want 3 5 ff", i, rsp1_c, rsp1_tag, rsp0_c);
      end
      @(negedge clk);
    end
    rsp1_ready = 1'b1;
    #1;
    checks++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      errors++; $display("FAIL bp_release: r0=%0b r1=%0b, want 0 1", req0_ready, req1_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (rsp1_c !== 32'd42 || rsp1_tag !== 4'd6) begin
      errors++; $display("FAIL bp_release_rsp: c=%0d t=%0d, want 42 6", rsp1_c, rsp1_tag);
    end
    @(negedge clk);
    idle();
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    set_req(0, OP_BEQ, 32'd7, 32'd7, 4'd1);
    @(posedge clk); #1;
    checks++;
    if (rsp0_valid !== 1'b1 || rsp0_f !== 1'b1) begin
      errors++; $display("FAIL b2b_first: v=%0b f=%0b, want 1 1", rsp0_valid, rsp0_f);
    end
    @(negedge clk);
    set_req(0, OP_BNE, 32'd7, 32'd7, 4'd2);
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_ready: got %0b want 1", req0_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (rsp0_valid !== 1'b1 || rsp0_f !== 1'b0 || rsp0_tag !== 4'd2) begin
      errors++; $display("FAIL b2b_second: v=%0b f=%0b t=%0d, want 1 0 2", rsp0_valid, rsp0_f, rsp0_tag);
    end
    @(negedge clk);
    idle();
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    set_req(0, OP_ADD, 32'd1, 32'd1, 4'd1);
    set_req(1, OP_ADD, 32'd2, 32'd2, 4'd2);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    checks++;
    if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b1) begin
      errors++; $display("FAIL arst_setup: v0=%0b v1=%0b, want 1 1", rsp0_valid, rsp1_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
      errors++; $display("FAIL arst_clear: v0=%0b v1=%0b, want 0 0", rsp0_valid, rsp1_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    set_req(0, OP_ADD, 32'd1, 32'd1, 4'd1);
    set_req(1, OP_ADD, 32'd2, 32'd2, 4'd2);
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL arst_rr: r0=%0b r1=%0b, want 1 0", req0_ready, req1_ready);
    end
    @(negedge clk);
    idle();
  endtask

`ifdef ALU_ARB_STATS_EN
  task automatic test_stats();
    @(negedge clk);
    rst_n = 1'b0;
    idle();
    #2 rst_n = 1'b1;
    set_req(0, OP_ADD, 32'd1, 32'd1, 4'd1);
    set_req(1, OP_BEQ, 32'd1, 32'd1, 4'd2);
    repeat (10) @(negedge clk);
    idle();
    checks++;
    if (stat_conflict !== 32'd10 || stat_gnt0 !== 32'd5 || stat_gnt1 !== 32'd5) begin
      errors++; $display("FAIL stats: conf=%0d g0=%0d g1=%0d, want 10 5 5", stat_conflict, stat_gnt0, stat_gnt1);
    end
  endtask
`endif

  task automatic test_random(input int n);
    logic        v[2], rdy[2], hold[2], e[2];
    logic [3:0]  op[2], tg[2];
    logic [31:0] a[2], b[2];
    logic        mv[2], mf[2], mbr[2];
    logic [31:0] mc[2];
    logic [3:0]  mt[2];
    logic [32:0] r;
    int          favour, g;
    @(negedge clk);
    rst_n = 1'b0;
    idle();
    #2 rst_n = 1'b1;
    favour = 0;
    for (int p = 0; p < 2; p++) begin
      hold[p] = 1'b0; mv[p] = 1'b0; mf[p] = 1'b0; mbr[p] = 1'b0; mc[p] = '0; mt[p] = '0;
      v[p] = 1'b0; op[p] = '0; tg[p] = '0; a[p] = '0; b[p] = '0;
    end
    for (int cyc = 0; cyc < n; cyc++) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        if (!hold[p]) begin
          v[p]  = ($urandom % 4) != 0;
          op[p] = 4'($urandom_range(0, 11));
          a[p]  = ($urandom % 2) ? $urandom : 32'($urandom_range(0, 20));
          b[p]  = ($urandom % 2) ? $urandom : 32'($urandom_range(0, 20));
          tg[p] = 4'($urandom);
        end
        rdy[p] = ($urandom % 3) != 0;
      end
      req0_valid = v[0]; req0_op = op[0]; req0_a = a[0]; req0_b = b[0]; req0_tag = tg[0];
      req1_valid = v[1]; req1_op = op[1]; req1_a = a[1]; req1_b = b[1]; req1_tag = tg[1];
      rsp0_ready = rdy[0]; rsp1_ready = rdy[1];
      for (int p = 0; p < 2; p++) e[p] = v[p] && (!mv[p] || rdy[p]);
      if (e[0] && e[1]) g = favour;
      else if (e[0])    g = 0;
      else if (e[1])    g = 1;
      else              g = -1;
      #1;
      checks++;
      if (req0_ready !== (g == 0) || req1_ready !== (g == 1)) begin
        errors++; $display("FAIL rnd_grant@%0d: r0=%0b r1=%0b, want grant %0d", cyc, req0_ready, req1_ready, g);
      end
      checks++;
      if (g < 0 && (alu_op !== OP_ADD || alu_a !== a[0] || alu_b !== b[0])) begin
        errors++; $display("FAIL rnd_idle_drive@%0d: op=%0d a=%0h b=%0h, want ADD %0h %0h", cyc, alu_op, alu_a, alu_b, a[0], b[0]);
      end
      @(posedge clk); #1;
      if (e[0] && e[1]) favour = 1 - g;
      for (int p = 0; p < 2; p++) begin
        if (g == p) begin
          r = alu_ref(op[p], a[p], b[p]);
          mv[p] = 1'b1; mc[p] = r[31:0]; mf[p] = r[32]; mt[p] = tg[p];
          mbr[p] = (op[p] >= OP_BEQ);
        end else if (mv[p] && rdy[p]) begin
          mv[p] = 1'b0;
        end
        hold[p] = v[p] && (g != p);
      end
      checks++;
      if (rsp0_valid !== mv[0] || (mv[0] && (rsp0_tag !== mt[0] ||
          (!mbr[0] && rsp0_c !== mc[0]) || (mbr[0] && rsp0_f !== mf[0])))) begin
        errors++; $display("FAIL rnd_rsp0@%0d: v=%0b c=%0h f=%0b t=%0h, want v=%0b c=%0h f=%0b t=%0h br=%0b",
                           cyc, rsp0_valid, rsp0_c, rsp0_f, rsp0_tag, mv[0], mc[0], mf[0], mt[0], mbr[0]);
      end
      checks++;
      if (rsp1_valid !== mv[1] || (mv[1] && (rsp1_tag !== mt[1] ||
          (!mbr[1] && rsp1_c !== mc[1]) || (mbr[1] && rsp1_f !== mf[1])))) begin
        errors++; $display("FAIL rnd_rsp1@%0d: v=%0b c=%0h f=%0b t=%0h, want v=%0b c=%0h f=%0b t=%0h br=%0b",
                           cyc, rsp1_valid, rsp1_c, rsp1_f, rsp1_tag, mv[1], mc[1], mf[1], mt[1], mbr[1]);
      end
    end
    @(negedge clk);
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time budget");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_backpressure();
    test_back_to_back();
    test_async_reset();
    test_random(400);
`ifdef ALU_ARB_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
